// File: rtl/writeback_arbiter.sv
// Writeback arbiter: two per-source result FIFOs drained round-robin
// into a single registered register-file write port.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_wr_addr,
  input  logic [31:0] alu_result,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_wr_addr,
  input  logic [31:0] ld_data,
  output logic        rd_wr_en,
  output logic [4:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data,
  output logic        idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 37;

  typedef enum logic {
    LG_LD  = 1'b0,
    LG_ALU = 1'b1
  } lg_e;

  logic [EW-1:0] mem [2][FIFO_DEPTH];
  logic [PW-1:0] wp [2];
  logic [PW-1:0] rp [2];
  logic [CW-1:0] cnt [2];
  logic [EW-1:0] wdata [2];
  logic [1:0]    vld;
  logic [1:0]    rdy;
  logic [1:0]    ne;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [EW-1:0] head;
  lg_e           last_q;

  always_comb begin
    vld      = {ld_valid, alu_valid};
    wdata[0] = {alu_wr_addr, alu_result};
    wdata[1] = {ld_wr_addr, ld_data};
    for (int i = 0; i < 2; i++) begin
      rdy[i]  = cnt[i] != CW'(FIFO_DEPTH);
      ne[i]   = cnt[i] != '0;
      push[i] = vld[i] & rdy[i];
    end
    // On contention the source that lost last time wins
    if (ne[0] && ne[1])
      pop = (last_q == LG_ALU) ? 2'b10 : 2'b01;
    else
      pop = ne;
    head = pop[1] ? mem[1][rp[1]] : mem[0][rp[0]];
  end

  assign alu_ready = rdy[0];
  assign ld_ready  = rdy[1];
  assign idle      = (cnt[0] == '0) && (cnt[1] == '0) && !rd_wr_en;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i])
        mem[i][wp[i]] <= wdata[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
      last_q      <= LG_LD;
      rd_wr_en    <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i])
          wp[i] <= wp[i] + PW'(1);
        if (pop[i])
          rp[i] <= rp[i] + PW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (|pop)
        last_q <= pop[1] ? LG_LD : LG_ALU;
      // x0 entries are popped silently
      if (|pop && head[36:32] != 5'd0) begin
        rd_wr_en    <= 1'b1;
        reg_wr_addr <= head[36:32];
        reg_wr_data <= head[31:0];
      end else begin
        rd_wr_en    <= 1'b0;
        reg_wr_addr <= '0;
        reg_wr_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a
// queue-based reference model.
module tb_writeback_arbiter;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_wr_addr = '0;
  logic [31:0] alu_result = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_wr_addr = '0;
  logic [31:0] ld_data = '0;
  logic        rd_wr_en;
  logic [4:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        idle;

  writeback_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk(clk),
    .reset(reset),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_wr_addr(alu_wr_addr),
    .alu_result(alu_result),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_wr_addr(ld_wr_addr),
    .ld_data(ld_data),
    .rd_wr_en(rd_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t pa[$];
  ent_t pl[$];
  ent_t aq[$];
  ent_t lq[$];
  bit          alu_turn;
  bit          mok;
  bit          e_we;
  logic [4:0]  e_ad;
  logic [31:0] e_dt;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic ent_t mk(logic [4:0] a, logic [31:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic exp_wr(string tag, logic [4:0] a, logic [31:0] d);
    chk({tag, "_we"}, 32'(rd_wr_en), 32'd1);
    chk({tag, "_ad"}, 32'(reg_wr_addr), 32'(a));
    chk({tag, "_dt"}, reg_wr_data, d);
  endtask

  task automatic exp_none(string tag);
    chk({tag, "_we"}, 32'(rd_wr_en), 32'd0);
    chk({tag, "_ad"}, 32'(reg_wr_addr), 32'd0);
    chk({tag, "_dt"}, reg_wr_data, 32'd0);
  endtask

  // One clock: drive pending heads, check DUT against model, advance model
  task automatic tick(bit rst);
    ent_t e;
    bit   a_acc;
    bit   l_acc;
    int   g;
    reset     = rst;
    alu_valid = pa.size() > 0;
    ld_valid  = pl.size() > 0;
    if (alu_valid) begin
      alu_wr_addr = pa[0].a;
      alu_result  = pa[0].d;
    end
    if (ld_valid) begin
      ld_wr_addr = pl[0].a;
      ld_data    = pl[0].d;
    end
    if (mok) begin
      chk("alu_ready", 32'(alu_ready), 32'(aq.size() < D));
      chk("ld_ready", 32'(ld_ready), 32'(lq.size() < D));
      chk("we", 32'(rd_wr_en), 32'(e_we));
      chk("addr", 32'(reg_wr_addr), 32'(e_ad));
      chk("data", reg_wr_data, e_dt);
      chk("idle", 32'(idle),
          32'(aq.size() == 0 && lq.size() == 0 && !e_we));
    end
    @(posedge clk);
    if (rst) begin
      aq.delete();
      lq.delete();
      pa.delete();
      pl.delete();
      alu_turn = 1'b1;
      e_we = 1'b0;
      e_ad = '0;
      e_dt = '0;
      mok = 1'b1;
    end else begin
      a_acc = pa.size() > 0 && aq.size() < D;
      l_acc = pl.size() > 0 && lq.size() < D;
      g = 0;
      if (aq.size() > 0 && lq.size() > 0)
        g = alu_turn ? 1 : 2;
      else if (aq.size() > 0)
        g = 1;
      else if (lq.size() > 0)
        g = 2;
      e_we = 1'b0;
      e_ad = '0;
      e_dt = '0;
      if (g != 0) begin
        if (g == 1)
          e = aq.pop_front();
        else
          e = lq.pop_front();
        alu_turn = (g == 2);
        if (e.a != 5'd0) begin
          e_we = 1'b1;
          e_ad = e.a;
          e_dt = e.d;
        end
      end
      if (a_acc)
        aq.push_back(pa.pop_front());
      if (l_acc)
        lq.push_back(pl.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    int nw;
    int na;
    ent_t e;
    mok = 1'b0;
    @(negedge clk);
    tick(1'b1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ardy", 32'(alu_ready), 32'd1);
    chk("rst_lrdy", 32'(ld_ready), 32'd1);
    exp_none("rst");

    pa.push_back(mk(5'd5, 32'hDEADBEEF));
    tick(1'b0);
    tick(1'b0);
    exp_wr("single", 5'd5, 32'hDEADBEEF);
    tick(1'b0);
    exp_none("single_after");
    chk("single_idle", 32'(idle), 32'd1);

    tick(1'b1);
    pa.push_back(mk(5'd3, 32'h11));
    pl.push_back(mk(5'd4, 32'h22));
    tick(1'b0);
    pa.push_back(mk(5'd6, 32'h33));
    pl.push_back(mk(5'd7, 32'h44));
    tick(1'b0);
    exp_wr("rr_r3", 5'd3, 32'h11);
    tick(1'b0);
    exp_wr("rr_r4", 5'd4, 32'h22);
    tick(1'b0);
    exp_wr("rr_r6", 5'd6, 32'h33);
    tick(1'b0);
    exp_wr("rr_r7", 5'd7, 32'h44);

    tick(1'b1);
    for (int i = 0; i < 3; i++)
      pl.push_back(mk(5'(9 + i), 32'hA0 + 32'(i)));
    for (int i = 0; i < 4; i++)
      pa.push_back(mk(5'(1 + i), 32'hB0 + 32'(i)));
    tick(1'b0);
    tick(1'b0);
    chk("full_ldrdy", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (rd_wr_en && reg_wr_addr >= 5'd9 && reg_wr_addr <= 5'd11)
        got.push_back(int'(reg_wr_addr));
      tick(1'b0);
    end
    chk("full_n", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got.size())
        chk("full_ord", 32'(got[i]), 32'(9 + i));

    tick(1'b1);
    pa.push_back(mk(5'd0, 32'h1234));
    tick(1'b0);
    tick(1'b0);
    exp_none("x0");
    chk("x0_idle", 32'(idle), 32'd1);
    tick(1'b0);
    exp_none("x0_after");

    tick(1'b1);
    for (int i = 0; i < 10; i++) begin
      pa.push_back(mk(5'(1 + i), $urandom));
      pl.push_back(mk(5'(17 + i), $urandom));
    end
    tick(1'b0);
    nw = 0;
    na = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      if (rd_wr_en)
        nw++;
      if (rd_wr_en && reg_wr_addr < 5'd16)
        na++;
    end
    chk("stream_wr", 32'(nw), 32'd8);
    chk("stream_alu", 32'(na), 32'd4);

    tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      pa.push_back(mk(5'(1 + i), 32'hC0 + 32'(i)));
      pl.push_back(mk(5'(17 + i), 32'hD0 + 32'(i)));
    end
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    exp_none("midrst");
    chk("midrst_ardy", 32'(alu_ready), 32'd1);
    chk("midrst_lrdy", 32'(ld_ready), 32'd1);
    chk("midrst_idle", 32'(idle), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      exp_none("midrst_stale");
    end

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0 && pa.size() < 4) begin
        e.a = 5'($urandom_range(0, 31));
        e.d = $urandom;
        pa.push_back(e);
      end
      if ($urandom_range(0, 2) != 0 && pl.size() < 4) begin
        e.a = 5'($urandom_range(0, 31));
        e.d = $urandom;
        pl.push_back(e);
      end
      tick($urandom_range(0, 99) == 0);
    end
    pa.delete();
    pl.delete();
    for (int i = 0; i < 20; i++)
      if (aq.size() > 0 || lq.size() > 0 || e_we)
        tick(1'b0);
    chk("drain_idle", 32'(idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
